// File: rtl/bulls_cows_pkg.sv
// Shared types and board defaults for the bullsCows input/game slice.
package bulls_cows_pkg;

    // Debouncer states; RELEASE_WAIT doubles as the reset state so a held
    // button must be seen released before it can be accepted.
    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } debounce_state_t;

    localparam int unsigned DEFAULT_CLK_FREQ_HZ = 100_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_MS = 10;
    localparam int unsigned GUESS_WIDTH         = 16;

endpackage

// File: rtl/confirm_input_conditioner_input_sync.sv
// Multi-flop synchroniser chain for asynchronous board inputs.
module input_sync #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] chain [STAGES];

    // Shift the raw input through STAGES flops, all cleared on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) begin
                chain[i] <= '0;
            end
        end else begin
            chain[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                chain[i] <= chain[i-1];
            end
        end
    end

    assign q = chain[STAGES-1];

endmodule

// File: rtl/confirm_input_conditioner.sv
// Synchronises the guess switches and confirm button, debounces the button
// and emits a one-cycle confirm pulse with a switch snapshot.
module confirm_input_conditioner
    import bulls_cows_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ     = DEFAULT_CLK_FREQ_HZ,
    parameter int unsigned DEBOUNCE_MS     = DEFAULT_DEBOUNCE_MS,
    parameter int unsigned DEBOUNCE_CYCLES = CLK_FREQ_HZ / 1000 * DEBOUNCE_MS,
    parameter int unsigned SW_WIDTH        = GUESS_WIDTH,
    parameter int unsigned SYNC_STAGES     = 2
) (
    input  logic                clock,
    input  logic                CPU_RESETN,
    input  logic [SW_WIDTH-1:0] SW,
    input  logic                btn_confirm,
    output logic [SW_WIDTH-1:0] guess,
    output logic                confirm,
    output logic                btn_level
);

    localparam int unsigned         CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

    logic [SW_WIDTH-1:0] sw_s;
    logic                btn_s;

    debounce_state_t     state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n, cnt_inc;
    logic                pulse;
    logic                level_n;

    input_sync #(
        .WIDTH  (SW_WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .clk   (clock),
        .rst_n (CPU_RESETN),
        .d     (SW),
        .q     (sw_s)
    );

    input_sync #(
        .WIDTH  (1),
        .STAGES (SYNC_STAGES)
    ) u_btn_sync (
        .clk   (clock),
        .rst_n (CPU_RESETN),
        .d     (btn_confirm),
        .q     (btn_s)
    );

    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // Next-state, counter and pulse decision; the entering sample counts as 1.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        pulse   = 1'b0;
        unique case (state)
            IDLE: begin
                if (btn_s) begin
                    state_n = PRESS_WAIT;
                    cnt_n   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                    pulse   = 1'b1;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            PRESSED: begin
                if (!btn_s) begin
                    state_n = RELEASE_WAIT;
                    cnt_n   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_n = PRESSED;
                    cnt_n   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt_inc;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
        // Level follows the state, except the post-reset RELEASE_WAIT keeps it
        // low until the button has actually been seen pressed.
        level_n = (state_n == PRESSED) || (btn_level && (state_n == RELEASE_WAIT));
    end

    // State, counter and registered outputs; guess only moves on a pulse.
    always_ff @(posedge clock) begin
        if (!CPU_RESETN) begin
            state     <= RELEASE_WAIT;
            cnt       <= '0;
            confirm   <= 1'b0;
            btn_level <= 1'b0;
            guess     <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            confirm   <= pulse;
            btn_level <= level_n;
            if (pulse) begin
                guess <= sw_s;
            end
        end
    end

endmodule

// File: doc/confirm_input_conditioner.md
Name: confirm_input_conditioner

Overview:
Board-level input stage directly upstream of the bullsCows game core. It synchronises the 16 guess switches and the raw confirm push-button into the clock domain, and debounces the button. It emits a single-cycle confirm pulse with a registered snapshot of the switches taken on that same pulse. The game core therefore only ever sees a clean one-cycle confirm and a guess that is stable for the whole round.

Parameters:
CLK_FREQ_HZ, 100_000_000, board clock frequency.
DEBOUNCE_MS, 10, required stable time of the button level.
DEBOUNCE_CYCLES, CLK_FREQ_HZ/1000*DEBOUNCE_MS, stable-sample count. Overridable for simulation. Must be ≥2.
SW_WIDTH, 16, guess switch width.
SYNC_STAGES, 2, synchroniser depth. Must be ≥2.

Ports:
clock  in  1  board clock; all logic on the rising edge.
CPU_RESETN  in  1  synchronous, active-low reset.
SW  in  SW_WIDTH  raw asynchronous switches.
btn_confirm  in  1  raw asynchronous, bouncing push-button (1 = pressed).
guess  out  SW_WIDTH  switch snapshot, valid from the confirm cycle onward.
confirm  out  1  one-clock pulse per debounced press.
btn_level  out  1  debounced button level (1 while in PRESSED or RELEASE_WAIT).

Behaviour:
- Reset (CPU_RESETN=0 sampled on a rising edge):
  - Synchroniser flops, guess, confirm, btn_level and the counter all go to 0.
  - The FSM goes to RELEASE_WAIT.
  - Reset overrides all other activity. A pulse is never emitted in a cycle where reset is sampled.
- Synchronisation:
  - SW and btn_confirm each pass through SYNC_STAGES flops, giving sw_s and btn_s.
  - Switches are not debounced. The snapshot is taken only at confirm time.
- Counter: width $clog2(DEBOUNCE_CYCLES+1). It clears on every state change and saturates; it never wraps.
- FSM:
  - IDLE (released, armed):
    - btn_s=1 → PRESS_WAIT, counter=1.
  - PRESS_WAIT:
    - btn_s=0 → IDLE (bounce rejected, no pulse).
    - btn_s=1 and counter==DEBOUNCE_CYCLES-1 → PRESSED.
    - On that same edge: confirm<=1 and guess<=sw_s.
    - Otherwise counter++.
  - PRESSED:
    - confirm returns to 0 on the next edge; there is no auto-repeat while held.
    - btn_s=0 → RELEASE_WAIT, counter=1.
  - RELEASE_WAIT:
    - btn_s=1 → PRESSED (release bounce, no new pulse).
    - btn_s=0 and counter==DEBOUNCE_CYCLES-1 → IDLE.
    - Otherwise counter++.
- btn_level is 1 only in PRESSED and RELEASE_WAIT. It is 0 after reset: the reset state is RELEASE_WAIT, but no press has been debounced yet.
- Button held through reset: the reset state is RELEASE_WAIT, so a held button produces no pulse until it has been released for DEBOUNCE_CYCLES samples and then pressed again.
- Latency: a clean press first sampled on edge T makes confirm=1 in the cycle after edge T+SYNC_STAGES+DEBOUNCE_CYCLES-1, and it lasts exactly one cycle.
- guess holds its value between pulses, independent of later SW activity. It changes only on a confirm edge or on reset.
- Outputs are registered. There are no combinational paths from input to output.

Decomposition:
- Shared package bulls_cows_pkg holds:
  - typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} debounce_state_t.
  - Constants DEFAULT_CLK_FREQ_HZ and DEFAULT_DEBOUNCE_MS.
  - Constant GUESS_WIDTH=16.
- One sub-module, input_sync: a parameterised WIDTH×SYNC_STAGES flop chain with synchronous active-low reset to 0.
  - Instantiated once for SW and once for btn_confirm.

Test Plan:
Bench parameters are DEBOUNCE_CYCLES=8 and SYNC_STAGES=2. Every scenario first releases reset with the button low for ≥10 cycles.
1. Clean press: SW=16'h1234; btn_confirm goes high at edge T and holds 40 cycles → confirm=1 for exactly one cycle (after edge T+9), guess=16'h1234 in that cycle; btn_level=1; no further pulse.
2. Press bounce: btn high 5 cycles, low 2, high 5, low 20 → confirm stays 0. Then high 20 cycles → exactly one pulse.
3. Release bounce: after a pulse, btn low 3, high 3, low 20 → no second pulse; btn_level falls after 8 low samples; the next clean press gives one pulse.
4. Held through reset: btn high while CPU_RESETN=0 and after its release for 50 cycles → confirm=0. Then btn low 12 cycles, high 12 cycles → one pulse.
5. Snapshot hold: press with SW=16'h0A5F, then SW=16'hFFFF while held and after release → guess stays 16'h0A5F. Next press → guess=16'hFFFF.
6. Reset mid-count: btn high 5 cycles, then CPU_RESETN=0 for 1 cycle with btn still high → confirm never asserts; guess=0 and btn_level=0 after reset.
